// File: rtl/uart_rx_vote_sampler.sv
// Mid-bit majority-vote sampler for the UART receiver with its own oversampling edge counter.
// Latency: sample_valid/bit_done are registered, one cycle after the deciding/last edge.
// Backpressure: none; the line cannot be stalled, samp_en low simply idles the counter.
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int VOTES      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  samp_en,
    input  logic                  bit_sync,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  bit_done,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  cfg_err
);

    localparam int ACC_W = (VOTES > 1) ? $clog2(VOTES + 1) : 1;
    localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(VOTES + 1);
    localparam logic [PRESCALE_W-1:0] P_MAX  = PRESCALE_W'((1 << PRESCALE_W) - 2);
    localparam logic [PRESCALE_W-1:0] HALF_W = PRESCALE_W'((VOTES - 1) / 2);
    localparam logic [ACC_W-1:0]      HALF_A = ACC_W'((VOTES - 1) / 2);
    localparam logic [ACC_W-1:0]      ALL_A  = ACC_W'(VOTES);

    // A ratio is usable only if it is even and leaves room for the whole vote window.
    function automatic logic is_legal(input logic [PRESCALE_W-1:0] p);
        return (p[0] == 1'b0) && (p >= P_MIN) && (p <= P_MAX);
    endfunction

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  en_q;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  bit_q, bit_d;
    logic                  noise_q, noise_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  cfg_q, cfg_d;

    logic                  rise;
    logic [PRESCALE_W-1:0] p_cur;
    logic                  legal_cur;
    logic                  wrap;
    logic [PRESCALE_W-1:0] centre;
    logic [PRESCALE_W-1:0] win_lo;
    logic [PRESCALE_W-1:0] win_hi;
    logic                  in_win;
    logic [ACC_W-1:0]      total;

    // Window geometry and vote arithmetic for the current edge; on the enable edge the
    // freshly presented ratio is used so a window starting at cnt 0 is not missed.
    always_comb begin
        rise      = samp_en & ~en_q;
        p_cur     = rise ? Prescale : p_q;
        legal_cur = is_legal(p_cur);
        wrap      = (cnt_q == (p_cur - PRESCALE_W'(1)));
        centre    = (p_cur >> 1) - PRESCALE_W'(1);
        win_lo    = centre - HALF_W;
        win_hi    = centre + HALF_W;
        in_win    = (cnt_q >= win_lo) && (cnt_q <= win_hi);
        total     = acc_q + ACC_W'(RX_IN);
    end

    // Next-state: counter, ratio latch, accumulator and decision.
    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        cfg_d   = cfg_q;
        if (!samp_en) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (bit_sync) begin
            // Realignment wins over increment, wrap and any decision due this edge.
            cnt_d = '0;
            acc_d = '0;
            p_d   = Prescale;
            cfg_d = ~is_legal(Prescale);
        end else begin
            cnt_d  = wrap ? '0 : cnt_q + PRESCALE_W'(1);
            done_d = wrap;
            if (rise || wrap) begin
                p_d   = Prescale;
                cfg_d = ~is_legal(Prescale);
            end
            if (legal_cur && in_win) begin
                if (cnt_q == win_hi) begin
                    bit_d   = (total > HALF_A);
                    noise_d = (VOTES > 1) && (total != '0) && (total != ALL_A);
                    valid_d = 1'b1;
                    acc_d   = '0;
                end else begin
                    acc_d = total;
                end
            end
        end
    end

    // State registers, cleared asynchronously so no strobe survives a reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q   <= '0;
            p_q     <= '0;
            en_q    <= 1'b0;
            acc_q   <= '0;
            bit_q   <= 1'b0;
            noise_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            en_q    <= samp_en;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            noise_q <= noise_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cfg_q   <= cfg_d;
        end
    end

    assign sampled_bit  = bit_q;
    assign sample_valid = valid_q;
    assign noise_err    = noise_q;
    assign bit_done     = done_q;
    assign edge_cnt     = cnt_q;
    assign cfg_err      = cfg_q;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Directed bench for the vote sampler: a 3-vote and a 5-vote instance share stimulus.
// Expected per-bit decisions are queued when a bit is driven and popped on sample_valid.
// Timing of strobes, cfg_err, realignment and reset are checked at fixed step points.
module tb_uart_rx_vote_sampler;

    localparam int W = 6;

    logic         CLK = 1'b0;
    logic         RST;
    logic         RX_IN;
    logic         samp_en;
    logic         bit_sync;
    logic [W-1:0] Prescale;

    logic         sb3, sv3, ne3, bd3, cfg3;
    logic [W-1:0] ec3;
    logic         sb5, sv5, ne5, bd5, cfg5;
    logic [W-1:0] ec5;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] q3[$];
    logic [1:0] q5[$];

    uart_rx_vote_sampler #(.PRESCALE_W(W), .VOTES(3)) dut3 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .samp_en(samp_en), .bit_sync(bit_sync),
        .Prescale(Prescale), .sampled_bit(sb3), .sample_valid(sv3), .noise_err(ne3),
        .bit_done(bd3), .edge_cnt(ec3), .cfg_err(cfg3)
    );

    uart_rx_vote_sampler #(.PRESCALE_W(W), .VOTES(5)) dut5 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .samp_en(samp_en), .bit_sync(bit_sync),
        .Prescale(Prescale), .sampled_bit(sb5), .sample_valid(sv5), .noise_err(ne5),
        .bit_done(bd5), .edge_cnt(ec5), .cfg_err(cfg5)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are looked at 1 time unit after the rising edge.
    task automatic tick();
        logic [1:0] e;
        @(posedge CLK);
        #1;
        if (sv3) begin
            if (q3.size() == 0) check("valid3_unexpected", 32'(sv3), 0);
            else begin
                e = q3.pop_front();
                check("bit3_noise3", 32'({sb3, ne3}), 32'(e));
            end
        end
        if (sv5) begin
            if (q5.size() == 0) check("valid5_unexpected", 32'(sv5), 0);
            else begin
                e = q5.pop_front();
                check("bit5_noise5", 32'({sb5, ne5}), 32'(e));
            end
        end
    endtask

    task automatic idle(input int n);
        samp_en  = 1'b0;
        bit_sync = 1'b0;
        repeat (n) tick();
        check("idle_edge_cnt", 32'(ec3), 0);
    endtask

    // Drive one full bit period of p clocks starting at cnt 0; pat[c] is RX_IN on edge c.
    task automatic run_bit(input int p, input logic [31:0] pat, input bit legal,
                           input logic [1:0] e3, input logic [1:0] e5,
                           input int chg_at, input int chg_val);
        int nv3, nv5, nd, pos3, pos5, posd;
        nv3 = 0; nv5 = 0; nd = 0; pos3 = -1; pos5 = -1; posd = -1;
        samp_en  = 1'b1;
        bit_sync = 1'b0;
        if (legal) begin
            q3.push_back(e3);
            q5.push_back(e5);
        end
        for (int c = 0; c < p; c++) begin
            if (c == chg_at) Prescale = W'(chg_val);
            RX_IN = pat[c];
            tick();
            if (c == 0) begin
                check("cfg_err3", 32'(cfg3), 32'(!legal));
                check("cfg_err5", 32'(cfg5), 32'(!legal));
            end
            if (sv3) begin nv3++; pos3 = c; end
            if (sv5) begin nv5++; pos5 = c; end
            if (bd3) begin nd++;  posd = c; end
        end
        check("valid3_count", 32'(nv3), legal ? 1 : 0);
        check("valid5_count", 32'(nv5), legal ? 1 : 0);
        if (legal) begin
            check("valid3_edge", 32'(pos3), 32'(p / 2));
            check("valid5_edge", 32'(pos5), 32'(p / 2 + 1));
        end
        check("bit_done_count", 32'(nd), 1);
        check("bit_done_edge", 32'(posd), 32'(p - 1));
        check("wrap_edge_cnt", 32'(ec3), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sampled_bit"}, 32'(sb3), 0);
        check({tag, "_sample_valid"}, 32'(sv3), 0);
        check({tag, "_noise_err"}, 32'(ne3), 0);
        check({tag, "_bit_done"}, 32'(bd3), 0);
        check({tag, "_edge_cnt"}, 32'(ec3), 0);
        check({tag, "_cfg_err"}, 32'(cfg3), 0);
        check({tag, "_edge_cnt5"}, 32'(ec5), 0);
    endtask

    initial begin
        int nv, nd;
        RST      = 1'b0;
        RX_IN    = 1'b0;
        samp_en  = 1'b0;
        bit_sync = 1'b0;
        Prescale = W'(8);
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b1;
        idle(1);

        // P=8, line steady high for three bits.
        run_bit(8, 32'hFF, 1, 2'b10, 2'b10, -1, 0);
        run_bit(8, 32'hFF, 1, 2'b10, 2'b10, -1, 0);
        run_bit(8, 32'hFF, 1, 2'b10, 2'b10, -1, 0);

        // Decision holds across idle.
        Prescale = W'(16);
        idle(2);
        check("hold_sampled_bit", 32'(sb3), 1);
        check("hold_noise_err", 32'(ne3), 0);

        // P=16 glitch patterns.
        run_bit(16, 32'h0000_0080, 1, 2'b01, 2'b01, -1, 0);
        run_bit(16, 32'h0000_00C0, 1, 2'b11, 2'b01, -1, 0);

        // P=32, alternating 1,0,1,0,1 across the five-vote window 13..17.
        Prescale = W'(32);
        idle(2);
        run_bit(32, 32'h0002_A000, 1, 2'b01, 2'b11, -1, 0);
        run_bit(32, 32'h0002_A000, 1, 2'b01, 2'b11, -1, 0);

        // Ratio change mid-bit only takes effect at the wrap; next bit window is 2..4.
        Prescale = W'(16);
        idle(2);
        run_bit(16, 32'h0000_FFFF, 1, 2'b10, 2'b10, 5, 8);
        run_bit(8, 32'h0000_001C, 1, 2'b10, 2'b11, -1, 0);

        // Odd ratio: no votes, bit_done still pulses; legal ratio picked up at the wrap.
        Prescale = W'(7);
        idle(2);
        run_bit(7, 32'h7F, 0, 2'b00, 2'b00, 3, 8);
        run_bit(8, 32'hFF, 1, 2'b10, 2'b10, -1, 0);

        // Ratio too small for the window.
        Prescale = W'(2);
        idle(2);
        run_bit(2, 32'h3, 0, 2'b00, 2'b00, 1, 8);
        run_bit(8, 32'hFF, 1, 2'b10, 2'b10, -1, 0);

        // Realignment at cnt 7 with P=16 aborts the pending decision.
        Prescale = W'(16);
        idle(2);
        samp_en = 1'b1;
        RX_IN   = 1'b1;
        nv = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (sv3 || sv5) nv++;
        end
        check("pre_sync_edge_cnt", 32'(ec3), 7);
        bit_sync = 1'b1;
        tick();
        if (sv3 || sv5) nv++;
        bit_sync = 1'b0;
        check("sync_edge_cnt", 32'(ec3), 0);
        tick();
        if (sv3 || sv5) nv++;
        check("sync_no_valid", 32'(nv), 0);
        check("sync_restart_cnt", 32'(ec3), 1);
        idle(1);
        run_bit(16, 32'h0000_FFFF, 1, 2'b10, 2'b10, -1, 0);

        // Asynchronous reset in the middle of a bit.
        idle(2);
        samp_en = 1'b1;
        RX_IN   = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("pre_reset_edge_cnt", 32'(ec3), 6);
        RST = 1'b0;
        #1;
        check_all_zero("midbit_reset");
        samp_en = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        nv = 0;
        nd = 0;
        repeat (4) begin
            tick();
            if (sv3 || sv5) nv++;
            if (bd3 || bd5) nd++;
        end
        check("post_reset_valid", 32'(nv), 0);
        check("post_reset_done", 32'(nd), 0);
        check("q3_drained", 32'(q3.size()), 0);
        check("q5_drained", 32'(q5.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_vote_sampler.md
Name: uart_rx_vote_sampler

Overview:
Parametrised successor to the UART RX mid-bit sampler. It owns its own oversampling edge counter and accepts any even Prescale. The sample window is centred on mid-bit and takes a configurable odd number of votes. For each bit it produces a registered majority bit, a one-cycle valid strobe, a noise flag and an end-of-bit strobe. It sits between the RX line synchroniser and the UART RX FSM (start/parity/stop checks, deserialiser).

Parameters:
PRESCALE_W, 6, width of Prescale and of the internal edge counter; max Prescale = 2^PRESCALE_W - 2
VOTES, 3, number of consecutive samples in the majority vote; odd, legal 1..7

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  synchronised serial RX line
samp_en  input  1  sampling enable from RX FSM; low = idle
bit_sync  input  1  one-cycle pulse, restarts the bit period (start-edge realignment)
Prescale  input  PRESCALE_W  oversampling ratio, clocks per bit
sampled_bit  output  1  majority-voted bit value
sample_valid  output  1  one-cycle strobe, sampled_bit/noise_err updated
noise_err  output  1  votes of the last bit were not unanimous
bit_done  output  1  one-cycle strobe on the last edge of each bit period
edge_cnt  output  PRESCALE_W  current edge index within the bit, 0..P-1
cfg_err  output  1  latched Prescale illegal; no sampling while high

Behaviour:
- Reset (RST low, async): edge_cnt=0, sampled_bit=0, sample_valid=0, noise_err=0, bit_done=0, cfg_err=0, vote accumulator=0, latched prescale P=0.
- Prescale latch: P captures Prescale on (a) the cycle samp_en is sampled high after being low, (b) bit_sync, (c) the wrap edge cnt==P-1. A Prescale change mid-bit takes effect only at the next latch point.
- Legality: P legal iff P even and VOTES+1 <= P <= 2^PRESCALE_W-2. Illegal P: cfg_err=1 and held until the next latch point; counter still runs; no votes, no sample_valid; bit_done still pulses.
- Edge counter: samp_en low -> cnt=0, accumulator cleared, all strobes 0. samp_en high -> cnt increments each clock and wraps P-1 -> 0. bit_sync forces cnt=0 and clears the accumulator on the next edge, overriding increment/wrap in the same cycle.
- Window: centre C = P/2 - 1; H = (VOTES-1)/2; samples taken at cnt = C-H .. C+H inclusive (P=8,V=3 -> 2,3,4; P=16,V=3 -> 6,7,8; P=32,V=5 -> 13..17).
- Accumulator: ones count, width clog2(VOTES+1); adds RX_IN at each window edge.
- Decision: at cnt = C+H, sampled_bit <= (acc + RX_IN) > H, and noise_err <= total not in {0, VOTES}. sample_valid is high the cycle after this edge (registered), for exactly one cycle. The accumulator clears on the same edge.
- sampled_bit and noise_err hold between decisions and across samp_en low. They are cleared only by reset.
- bit_done is registered: high the cycle after the cnt = P-1 edge.
- Simultaneous events: bit_sync on a decision edge aborts that decision (no sample_valid). samp_en falling on a decision edge also aborts it.
- Reset mid-bit: all state cleared asynchronously; no strobe is emitted on reset release.
- Single-vote build (VOTES=1): one sample at cnt=C; noise_err is constant 0.

Test Plan:
- P=8, V=3, RX_IN=1 steady, samp_en high 3 bits -> sample_valid after cnt=4 edge of each bit; sampled_bit=1, noise_err=0; bit_done every 8 clocks.
- P=16, V=3, RX_IN=0 except a 1 at cnt=7 -> sampled_bit=0, noise_err=1; at cnt=6..8 = 1,1,0 -> sampled_bit=1, noise_err=1.
- P=32, V=5, pattern 1,0,1,0,1 on cnt=13..17 -> sampled_bit=1, noise_err=1, sample_valid exactly once per 32 clocks.
- Prescale 16 -> 8 at cnt=5 -> current bit finishes with P=16 (wrap at 15); next bit uses window 2..4.
- Prescale=7 (odd) or 2 (< VOTES+1) latched -> cfg_err=1, no sample_valid; Prescale=8 at next wrap -> cfg_err=0, sampling resumes.
- bit_sync at cnt=7 with P=16 -> no sample_valid that bit, cnt restarts at 0; RST low at cnt=6 -> all outputs 0 immediately, no strobe after release.
